alu_issue: RTL

Decode/issue stage that drives the ALU's operation and operand inputs and closes the loop by writing the ALU result back. Accepts a 12-bit instruction stream over a valid/ready handshake. Decodes each instruction, reads a 4-entry register file and registers `alu_op`/`op1`/`op2` into an execute (EX) stage. Captures the combinational ALU result one cycle later into the register file and a carry flag.

---
 rtl/alu_issue_pkg.sv | 34 +++
 rtl/issue_regfile.sv | 42 ++++
 rtl/alu_issue.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/alu_issue_pkg.sv
// Shared opcode, field and register-file constants for the alu_issue slice.
// Field LSBs below the immediate are given as offsets from WIDTH.
package alu_issue_pkg;

    localparam int OPC_W     = 3;
    localparam int REG_IDX_W = 2;
    localparam int NUM_REGS  = 4;

    // rs1 LSB = WIDTH - RS1_OFS, rs2 LSB = WIDTH - RS2_OFS, rd LSB = WIDTH
    localparam int RS1_OFS   = 2;
    localparam int RS2_OFS   = 4;

    typedef logic [REG_IDX_W-1:0] reg_idx_t;

    typedef enum logic [OPC_W-1:0] {
        OP_NOP = 3'b000,
        OP_ADD = 3'b001,
        OP_SUB = 3'b010,
        OP_AND = 3'b011,
        OP_OR  = 3'b100,
        OP_XOR = 3'b101,
        OP_LI  = 3'b110,
        OP_ILL = 3'b111
    } opcode_e;

    function automatic logic is_alu(input logic [OPC_W-1:0] op);
        return op inside {OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR};
    endfunction

    function automatic logic is_arith(input logic [OPC_W-1:0] op);
        return op inside {OP_ADD, OP_SUB};
    endfunction

endpackage

// File: rtl/issue_regfile.sv
// 4-entry register file: two asynchronous read ports, one synchronous
// write port, asynchronous active-high reset to zero.
module issue_regfile
    import alu_issue_pkg::*;
#(
    parameter int WIDTH = 7
) (
    input  logic             clk,
    input  logic             rst,
    input  reg_idx_t         ra1,
    input  reg_idx_t         ra2,
    output logic [WIDTH-1:0] rd1,
    output logic [WIDTH-1:0] rd2,
    input  logic             we,
    input  reg_idx_t         wa,
    input  logic [WIDTH-1:0] wd
);

    logic [WIDTH-1:0] regs_q [NUM_REGS];
    logic [WIDTH-1:0] regs_d [NUM_REGS];

    always_comb begin
        regs_d = regs_q;
        if (we) begin
            regs_d[wa] = wd;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            regs_q <= regs_d;
        end
    end

    assign rd1 = regs_q[ra1];
    assign rd2 = regs_q[ra2];

endmodule

// File: rtl/alu_issue.sv
// Decode/issue stage feeding an external ALU, with EX register and writeback.
// ALU_ISSUE_FWD_EN selects EX->decode forwarding; otherwise RAW hazards stall.
module alu_issue
    import alu_issue_pkg::*;
#(
    parameter int WIDTH    = 7,
    parameter int OP_WIDTH = 3
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [OP_WIDTH+2+WIDTH-1:0]     instr,
    input  logic                            instr_valid,
    output logic                            instr_ready,
    input  logic                            hold,
    output logic [OP_WIDTH-1:0]             alu_op,
    output logic [WIDTH-1:0]                op1,
    output logic [WIDTH-1:0]                op2,
    input  logic [WIDTH:0]                  alu_result,
    output logic                            wb_valid,
    output logic [1:0]                      wb_rd,
    output logic [WIDTH-1:0]                wb_data,
    output logic                            carry,
    output logic                            illegal_op
);

    localparam int IW = OP_WIDTH + REG_IDX_W + WIDTH;

    logic [OP_WIDTH-1:0] dec_op;
    reg_idx_t            dec_rd;
    reg_idx_t            dec_rs1;
    reg_idx_t            dec_rs2;
    logic [WIDTH-1:0]    dec_imm;

    assign dec_op  = instr[IW-1 -: OP_WIDTH];
    assign dec_rd  = instr[WIDTH +: REG_IDX_W];
    assign dec_rs1 = instr[WIDTH-RS1_OFS +: REG_IDX_W];
    assign dec_rs2 = instr[WIDTH-RS2_OFS +: REG_IDX_W];
    assign dec_imm = instr[WIDTH-1:0];

    logic                ex_valid_q, ex_valid_d;
    logic [OP_WIDTH-1:0] ex_op_q, ex_op_d;
    reg_idx_t            ex_rd_q, ex_rd_d;
    logic [OP_WIDTH-1:0] alu_op_q, alu_op_d;
    logic [WIDTH-1:0]    op1_q, op1_d;
    logic [WIDTH-1:0]    op2_q, op2_d;

    logic                wb_valid_q, wb_valid_d;
    reg_idx_t            wb_rd_q, wb_rd_d;
    logic [WIDTH-1:0]    wb_data_q, wb_data_d;
    logic                carry_q, carry_d;
    logic                illegal_q, illegal_d;

    logic [WIDTH-1:0]    rf_rd1, rf_rd2;
    logic [WIDTH-1:0]    op1_src, op2_src;
    logic                ex_writes;
    logic [WIDTH-1:0]    ex_wdata;
    logic                stall;
    logic                accept;

    assign ex_writes = ex_valid_q
                     && (is_alu(ex_op_q) || ex_op_q == OP_LI);
    // LI keeps its immediate in op2 and bypasses the ALU
    assign ex_wdata  = (ex_op_q == OP_LI) ? op2_q
                                          : alu_result[WIDTH-1:0];

    issue_regfile #(
        .WIDTH (WIDTH)
    ) u_rf (
        .clk (clk),
        .rst (rst),
        .ra1 (dec_rs1),
        .ra2 (dec_rs2),
        .rd1 (rf_rd1),
        .rd2 (rf_rd2),
        .we  (ex_writes),
        .wa  (ex_rd_q),
        .wd  (ex_wdata)
    );

    always_comb begin
        op1_src = rf_rd1;
        op2_src = rf_rd2;
        stall   = 1'b0;
`ifdef ALU_ISSUE_FWD_EN
        if (ex_writes && ex_rd_q == dec_rs1) begin
            op1_src = ex_wdata;
        end
        if (ex_writes && ex_rd_q == dec_rs2) begin
            op2_src = ex_wdata;
        end
`else
        stall = ex_writes && is_alu(dec_op)
             && (ex_rd_q == dec_rs1 || ex_rd_q == dec_rs2);
`endif
    end

    assign instr_ready = !rst && !hold && !stall;
    assign accept      = instr_valid && instr_ready;

    always_comb begin
        ex_valid_d = 1'b0;
        ex_op_d    = OP_NOP;
        ex_rd_d    = ex_rd_q;
        alu_op_d   = '0;
        op1_d      = op1_q;
        op2_d      = op2_q;
        if (accept) begin
            ex_valid_d = 1'b1;
            ex_op_d    = dec_op;
            ex_rd_d    = dec_rd;
            op1_d      = op1_src;
            op2_d      = (dec_op == OP_LI) ? dec_imm : op2_src;
            if (is_alu(dec_op)) begin
                alu_op_d = dec_op;
            end
        end
    end

    always_comb begin
        wb_valid_d = ex_writes;
        wb_rd_d    = wb_rd_q;
        wb_data_d  = wb_data_q;
        carry_d    = carry_q;
        illegal_d  = ex_valid_q && ex_op_q == OP_ILL;
        if (ex_writes) begin
            wb_rd_d   = ex_rd_q;
            wb_data_d = ex_wdata;
        end
        if (ex_valid_q && is_arith(ex_op_q)) begin
            carry_d = alu_result[WIDTH];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ex_valid_q <= 1'b0;
            ex_op_q    <= '0;
            ex_rd_q    <= '0;
            alu_op_q   <= '0;
            op1_q      <= '0;
            op2_q      <= '0;
            wb_valid_q <= 1'b0;
            wb_rd_q    <= '0;
            wb_data_q  <= '0;
            carry_q    <= 1'b0;
            illegal_q  <= 1'b0;
        end else begin
            ex_valid_q <= ex_valid_d;
            ex_op_q    <= ex_op_d;
            ex_rd_q    <= ex_rd_d;
            alu_op_q   <= alu_op_d;
            op1_q      <= op1_d;
            op2_q      <= op2_d;
            wb_valid_q <= wb_valid_d;
            wb_rd_q    <= wb_rd_d;
            wb_data_q  <= wb_data_d;
            carry_q    <= carry_d;
            illegal_q  <= illegal_d;
        end
    end

    assign alu_op     = alu_op_q;
    assign op1        = op1_q;
    assign op2        = op2_q;
    assign wb_valid   = wb_valid_q;
    assign wb_rd      = wb_rd_q;
    assign wb_data    = wb_data_q;
    assign carry      = carry_q;
    assign illegal_op = illegal_q;

endmodule
